// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with memory handshake, sticky illegal-opcode trap and instret.
module multicycle_control_fsm #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       imm_src,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             illegal_instr,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_LUI      = 4'd8,
      S_AUIPC    = 4'd9,
      S_JALR_ADR = 4'd10,
      S_JAL      = 4'd11,
      S_ALUWB    = 4'd12,
      S_BRANCH   = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] instret_reg;

   logic       mem_read_reg;
   logic       mem_write_reg;
   logic       adr_src_reg;
   logic [1:0] result_src_reg;
   logic [1:0] alu_src_a_reg;
   logic [1:0] alu_src_b_reg;
   logic [2:0] imm_src_reg;
   logic [1:0] alu_op_reg;
   logic       reg_write_reg;
   logic       illegal_reg;
   logic       fetch_reg;
   logic       jal_reg;
   logic       branch_reg;

   logic ready;
   logic unused_funct3;

   assign ready         = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign unused_funct3 = ^funct3[2:1];

   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD,
               OP_STORE:  state_next = S_MEMADR;
               OP_RTYPE:  state_next = S_EXEC_R;
               OP_ITYPE:  state_next = S_EXEC_I;
               OP_JAL:    state_next = S_JAL;
               OP_JALR:   state_next = S_JALR_ADR;
               OP_BRANCH: state_next = S_BRANCH;
               OP_LUI:    state_next = S_LUI;
               OP_AUIPC:  state_next = S_AUIPC;
               default:   state_next = S_TRAP;
            endcase
         end
         S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_next = ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = ready ? S_FETCH : S_MEMWRITE;
         S_EXEC_R:   state_next = S_ALUWB;
         S_EXEC_I:   state_next = S_ALUWB;
         S_LUI:      state_next = S_ALUWB;
         S_AUIPC:    state_next = S_ALUWB;
         S_JALR_ADR: state_next = S_JAL;
         S_JAL:      state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BRANCH:   state_next = S_FETCH;
         S_TRAP:     state_next = S_TRAP;
         default:    state_next = S_FETCH;
      endcase
   end

   // Output registers hold the decode of the state being entered, so they
   // resolve to the FETCH pattern on reset and are masked while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_FETCH;
         instret_reg    <= '0;
         mem_read_reg   <= 1'b1;
         mem_write_reg  <= 1'b0;
         adr_src_reg    <= 1'b0;
         result_src_reg <= 2'b10;
         alu_src_a_reg  <= 2'b00;
         alu_src_b_reg  <= 2'b10;
         imm_src_reg    <= 3'b000;
         alu_op_reg     <= 2'b00;
         reg_write_reg  <= 1'b0;
         illegal_reg    <= 1'b0;
         fetch_reg      <= 1'b1;
         jal_reg        <= 1'b0;
         branch_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_next == S_FETCH && state_reg != S_FETCH)
            instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};

         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         adr_src_reg    <= 1'b0;
         result_src_reg <= 2'b00;
         alu_src_a_reg  <= 2'b00;
         alu_src_b_reg  <= 2'b00;
         imm_src_reg    <= 3'b000;
         alu_op_reg     <= 2'b00;
         reg_write_reg  <= 1'b0;
         illegal_reg    <= 1'b0;
         fetch_reg      <= 1'b0;
         jal_reg        <= 1'b0;
         branch_reg     <= 1'b0;

         case (state_next)
            S_FETCH: begin
               mem_read_reg   <= 1'b1;
               result_src_reg <= 2'b10;
               alu_src_b_reg  <= 2'b10;
               fetch_reg      <= 1'b1;
            end
            S_DECODE: begin
               alu_src_a_reg <= 2'b01;
               alu_src_b_reg <= 2'b01;
               imm_src_reg   <= 3'b010;
            end
            S_MEMADR: begin
               alu_src_a_reg <= 2'b10;
               alu_src_b_reg <= 2'b01;
               imm_src_reg   <= opcode[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
               mem_read_reg <= 1'b1;
               adr_src_reg  <= 1'b1;
            end
            S_MEMWB: begin
               result_src_reg <= 2'b01;
               reg_write_reg  <= 1'b1;
            end
            S_MEMWRITE: begin
               mem_write_reg <= 1'b1;
               adr_src_reg   <= 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a_reg <= 2'b10;
               alu_op_reg    <= 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a_reg <= 2'b10;
               alu_src_b_reg <= 2'b01;
               alu_op_reg    <= 2'b10;
            end
            S_LUI: begin
               alu_src_a_reg <= 2'b11;
               alu_src_b_reg <= 2'b01;
               imm_src_reg   <= 3'b100;
            end
            S_AUIPC: begin
               alu_src_a_reg <= 2'b01;
               alu_src_b_reg <= 2'b01;
               imm_src_reg   <= 3'b100;
            end
            S_JALR_ADR: begin
               alu_src_a_reg <= 2'b10;
               alu_src_b_reg <= 2'b01;
            end
            S_JAL: begin
               alu_src_a_reg <= 2'b01;
               alu_src_b_reg <= 2'b10;
               jal_reg       <= 1'b1;
            end
            S_ALUWB: begin
               reg_write_reg <= 1'b1;
            end
            S_BRANCH: begin
               alu_src_a_reg <= 2'b10;
               alu_op_reg    <= 2'b01;
               branch_reg    <= 1'b1;
            end
            S_TRAP: begin
               illegal_reg <= 1'b1;
            end
            default: begin
               illegal_reg <= 1'b0;
            end
         endcase
      end
   end

   // funct3[0] flips the branch sense so BNE shares the BEQ compare.
   assign pc_write      = ((fetch_reg & ready) | jal_reg | (branch_reg & (zero ^ funct3[0]))) & ~rst;
   assign ir_write      = fetch_reg & ready & ~rst;
   assign mem_read      = mem_read_reg & ~rst;
   assign mem_write     = mem_write_reg & ~rst;
   assign adr_src       = adr_src_reg & ~rst;
   assign result_src    = result_src_reg & {2{~rst}};
   assign alu_src_a     = alu_src_a_reg & {2{~rst}};
   assign alu_src_b     = alu_src_b_reg & {2{~rst}};
   assign imm_src       = imm_src_reg & {3{~rst}};
   assign alu_op        = alu_op_reg & {2{~rst}};
   assign reg_write     = reg_write_reg & ~rst;
   assign illegal_instr = illegal_reg & ~rst;
   assign instret       = instret_reg;

endmodule
